seed_star_streamer: RTL
=======================

# seed_star_streamer

Downstream stage of the seed-tree generator. Captures the 1024-bit `seed_star` bundle (four 256-bit leaf hashes) on the generator's `tree_set_end` pulse. Splits it into eight 128-bit party seeds and streams them one per handshake to the tape/expansion stage. A two-slot ping-pong buffer lets the next tree run while the previous bundle drains.

## Interface
Parameters:
- `SEED_W`, 128: width of one emitted seed.
- `NUM_SEEDS`, 8: seeds per bundle; bundle width = `SEED_W*NUM_SEEDS`.

Ports:
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `seed_star`  in  1024: bundle from the seed tree; sampled only when `tree_set_end`=1.
- `t`  in  8: round tag; sampled together with `seed_star`.
- `tree_set_end`  in  1: one-cycle capture strobe.
- `can_accept`  out  1: at least one buffer slot is free; upstream gates `tree_start` on it.
- `seed_out`  out  128: current seed.
- `seed_idx`  out  3: index of `seed_out` within its bundle, 0..7.
- `seed_t`  out  8: round tag of the bundle being streamed.
- `seed_valid`  out  1: `seed_out`/`seed_idx`/`seed_t`/`seed_last` are valid.
- `seed_ready`  in  1: consumer accepts; transfer occurs when `seed_valid & seed_ready`.
- `seed_last`  out  1: `seed_idx`==7 while valid.
- `overrun`  out  1: sticky; a strobe arrived with both slots full.

## Operation
- Seed ordering: idx k = `seed_star[1023-128k -: 128]`. Idx 0 is the upper half of leaf 0, and idx 7 is `seed_star[127:0]`.
- Buffer:
  - Two slots, each holds 1024-bit data plus 8-bit tag.
  - 1-bit write pointer `wp`, 1-bit read pointer `rp`, 2-bit `count` (0..2).
- Capture on `tree_set_end`=1:
  - If `count`<2, or a last-seed transfer happens the same cycle: write slot[`wp`], toggle `wp`.
  - Otherwise: drop the data and set `overrun`.
- Output FSM:
  - IDLE: `seed_valid`=0. Moves to STREAM on the edge after `count` becomes nonzero.
  - STREAM: `seed_valid`=1. `seed_out` = slot[`rp`] seed `idx`. On each transfer, `idx`++.
  - Transfer with `idx`==7: `idx`←0 and `rp` toggles. Then stay in STREAM if the other slot is full, else go to IDLE.
- `count` update: +1 on capture, −1 on last transfer, unchanged when both occur in the same cycle.
- While valid and not ready, all outputs hold stable (AXI-style; no retraction).
- `can_accept` = (`count`<2), combinational from registers.
- `overrun` clears only on reset.
- Reset mid-operation: all contents are discarded; no partial bundle is resumed.

## Timing
- Reset values:
  - `seed_valid`=0, `seed_last`=0, `overrun`=0, `can_accept`=1.
  - `seed_idx`=0, `seed_out`=0, `seed_t`=0.
  - `count`=0, `wp`=`rp`=0, FSM=IDLE.
- Capture latency: strobe at edge N, so `seed_valid`=1 after edge N+1. First seed is visible one cycle after capture.
- Throughput: with `seed_ready` held at 1, one seed per cycle and 8 cycles per bundle.
- Back-to-back full bundles stream with no bubble between idx 7 and the next idx 0.
- `seed_out`, `seed_t` and `seed_last` may be a mux of registered state. `seed_valid` and `seed_idx` are registered.
- Boundary, `count`==2 with a strobe in the same cycle as the last transfer: the capture succeeds, `overrun` stays 0, and `count` stays 2.
- Boundary, `count`==2 with a strobe and no last transfer: `overrun`←1 and slot contents are unchanged.

## Structure
- Shared package holds:
  - `SEED_W`, `NUM_SEEDS` and `TAG_W`=8.
  - Typedef `seed_bundle_t` (1024-bit).
  - Function `seed_slice(bundle, idx)` implementing the ordering rule, reused by the verification model.
- One sub-module, `seed_slot_buf`: the two-slot storage with `wp`/`rp`/`count` and write/pop strobes. Top level owns the FSM and the index counter.

## Test plan
- Single bundle: `seed_star`=`{128'h00..00,128'h11..11,…,128'h77..77}`, `t`=8'h05, `seed_ready`=1.
  - Required: idx 0..7 emit 128'h00..00…128'h77..77 on 8 consecutive cycles.
  - `seed_t`=5 on every beat; `seed_last` only on idx 7; valid starts 1 cycle after strobe.
- Backpressure: toggle `seed_ready` 1,0,0,1 repeatedly.
  - Required: `seed_out`/`seed_idx` stable while stalled; no seed skipped or duplicated.
- Ping-pong: second strobe (`t`=6) during beat 3 of the first bundle.
  - Required: after idx 7 of `t`=5, idx 0 of `t`=6 follows with no gap.
  - `can_accept` reads 0 only while both slots are held.
- Overrun: `seed_ready`=0, three strobes.
  - Required: `overrun`=1 after the third strobe; the streamed data is from the first two bundles only.
- Simultaneous last-transfer and strobe with `count`==2.
  - Required: `overrun` stays 0 and the third bundle is streamed after the second.
- Reset asserted mid-bundle at idx 4.
  - Required: all outputs return to reset values immediately; after release, a new strobe streams from idx 0.

Source files
------------

// File: rtl/seed_star_streamer_pkg.sv
// Shared widths, types and the seed ordering rule for the seed_star streamer.
package seed_star_streamer_pkg;
    localparam int SEED_W    = 128;
    localparam int NUM_SEEDS = 8;
    localparam int TAG_W     = 8;
    localparam int BUNDLE_W  = SEED_W * NUM_SEEDS;
    localparam int IDX_W     = $clog2(NUM_SEEDS);

    typedef logic [BUNDLE_W-1:0] seed_bundle_t;
    typedef logic [SEED_W-1:0]   seed_word_t;
    typedef logic [TAG_W-1:0]    seed_tag_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } out_state_e;

    // Index 0 is the most significant seed of the bundle.
    function automatic seed_word_t seed_slice(input seed_bundle_t bundle,
                                              input logic [IDX_W-1:0] idx);
        return bundle[BUNDLE_W-1-SEED_W*int'(idx) -: SEED_W];
    endfunction
endpackage

// File: rtl/seed_star_streamer_slot_buf.sv
// Two-slot ping-pong store: write at wp, read at rp, count tracks occupancy.
module seed_slot_buf #(
    parameter int DATA_W = 1024,
    parameter int TAG_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic              pop,
    output logic [DATA_W-1:0] rd_data,
    output logic [TAG_W-1:0]  rd_tag,
    output logic [1:0]        count,
    output logic [1:0]        count_nxt
);
    logic [DATA_W-1:0] slot_q [2];
    logic [DATA_W-1:0] slot_d [2];
    logic [TAG_W-1:0]  tag_q  [2];
    logic [TAG_W-1:0]  tag_d  [2];
    logic              wp_q, wp_d, rp_q, rp_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        slot_d  = slot_q;
        tag_d   = tag_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        if (wr_en) begin
            slot_d[wp_q] = wr_data;
            tag_d[wp_q]  = wr_tag;
            wp_d         = ~wp_q;
        end
        if (pop) rp_d = ~rp_q;
        // Simultaneous write and pop leaves occupancy unchanged.
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                slot_q[i] <= '0;
                tag_q[i]  <= '0;
            end
            wp_q    <= 1'b0;
            rp_q    <= 1'b0;
            count_q <= 2'd0;
        end else begin
            slot_q  <= slot_d;
            tag_q   <= tag_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
        end
    end

    assign rd_data   = slot_q[rp_q];
    assign rd_tag    = tag_q[rp_q];
    assign count     = count_q;
    assign count_nxt = count_d;
endmodule

// File: rtl/seed_star_streamer.sv
// Captures seed_star bundles into a ping-pong buffer and streams them as
// NUM_SEEDS seeds over a valid/ready handshake.
module seed_star_streamer #(
    parameter int SEED_W    = 128,
    parameter int NUM_SEEDS = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [SEED_W*NUM_SEEDS-1:0] seed_star,
    input  logic [7:0]                  t,
    input  logic                        tree_set_end,
    output logic                        can_accept,
    output logic [SEED_W-1:0]           seed_out,
    output logic [$clog2(NUM_SEEDS)-1:0] seed_idx,
    output logic [7:0]                  seed_t,
    output logic                        seed_valid,
    input  logic                        seed_ready,
    output logic                        seed_last,
    output logic                        overrun
);
    import seed_star_streamer_pkg::*;

    localparam int LIDX_W = $clog2(NUM_SEEDS);
    localparam logic [LIDX_W-1:0] LAST_IDX = LIDX_W'(NUM_SEEDS - 1);

    out_state_e              state_q, state_d;
    logic [LIDX_W-1:0]       idx_q, idx_d;
    logic                    overrun_q, overrun_d;
    logic [SEED_W*NUM_SEEDS-1:0] rd_data;
    logic [7:0]              rd_tag;
    logic [1:0]              count, count_nxt;
    logic                    xfer, last_xfer, capture;

    assign xfer      = (state_q == ST_STREAM) && seed_ready;
    assign last_xfer = xfer && (idx_q == LAST_IDX);
    // A full buffer can still take a bundle when the last seed drains this cycle.
    assign capture   = tree_set_end && ((count != 2'd2) || last_xfer);

    seed_slot_buf #(
        .DATA_W (SEED_W*NUM_SEEDS),
        .TAG_W  (8)
    ) u_slot_buf (
        .clk       (clk),
        .reset     (reset),
        .wr_en     (capture),
        .wr_data   (seed_star),
        .wr_tag    (t),
        .pop       (last_xfer),
        .rd_data   (rd_data),
        .rd_tag    (rd_tag),
        .count     (count),
        .count_nxt (count_nxt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            overrun_q <= overrun_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (count != 2'd0) state_d = ST_STREAM;
            ST_STREAM: if (last_xfer && (count_nxt == 2'd0)) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        idx_d = idx_q;
        if (xfer) idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
        overrun_d = overrun_q || (tree_set_end && !capture);
    end

    always_comb begin
        seed_valid = (state_q == ST_STREAM);
        seed_idx   = idx_q;
        seed_out   = '0;
        seed_t     = '0;
        seed_last  = 1'b0;
        if (seed_valid) begin
            seed_out  = seed_slice(rd_data, idx_q);
            seed_t    = rd_tag;
            seed_last = (idx_q == LAST_IDX);
        end
        can_accept = (count != 2'd2);
        overrun    = overrun_q;
    end
endmodule
